// File: rtl/scalar_bit_scanner.sv
// Sequential MSB finder for a latched scalar: scans W bits per cycle from the top,
// then streams the scalar MSB-first from the highest set bit down to bit 0 over valid/ready.
module scalar_bit_scanner #(
    parameter  int N  = 255,
    parameter  int W  = 16,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  k,
    output logic          busy,
    output logic          msb_valid,
    output logic [IW-1:0] msb_idx,
    output logic          zero,
    output logic          bit_valid,
    output logic          bit_out,
    output logic [IW-1:0] bit_idx,
    input  logic          bit_ready,
    output logic          last,
    output logic          done
);
    localparam int C   = (N + W - 1) / W;
    localparam int CPW = (C > 1) ? $clog2(C) : 1;
    localparam int PSW = (W > 1) ? $clog2(W) : 1;
    localparam int PW  = C * W;

    typedef enum logic [1:0] {IDLE, SCAN, STREAM, DONE} state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   k_q, k_d;
    logic [CPW-1:0] chunk_q, chunk_d;
    logic           msb_valid_q, msb_valid_d;
    logic [IW-1:0]  msb_idx_q, msb_idx_d;
    logic           zero_q, zero_d;
    logic [IW-1:0]  bit_idx_q, bit_idx_d;

    logic [PW-1:0]  kPad;
    logic [W-1:0]   chunkBits;
    logic [PSW-1:0] chunkPos;
    logic           chunkHit;
    logic [IW-1:0]  scanIdx;

    // The top chunk may be partial; padding with zeros lets every chunk be read the same way.
    always_comb begin
        kPad           = '0;
        kPad[N-1:0]    = k_q;
        chunkBits      = kPad[int'(chunk_q) * W +: W];
    end

    always_comb begin
        chunkPos = '0;
        for (int i = 0; i < W; i++) begin
            if (chunkBits[i]) chunkPos = PSW'(i);
        end
    end

    assign chunkHit = |chunkBits;
    assign scanIdx  = IW'(int'(chunk_q) * W + int'(chunkPos));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (start) state_d = SCAN;
            SCAN: begin
                if (abort)                 state_d = IDLE;
                else if (chunkHit)         state_d = STREAM;
                else if (chunk_q == '0)    state_d = DONE;
            end
            STREAM: begin
                if (abort)                                state_d = IDLE;
                else if (bit_ready && bit_idx_q == '0)    state_d = DONE;
            end
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over a same-cycle handshake, so the index only moves when abort is low.
    always_comb begin
        k_d         = k_q;
        chunk_d     = chunk_q;
        msb_valid_d = msb_valid_q;
        msb_idx_d   = msb_idx_q;
        zero_d      = zero_q;
        bit_idx_d   = bit_idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k_d         = k;
                    chunk_d     = CPW'(C - 1);
                    msb_valid_d = 1'b0;
                    zero_d      = 1'b0;
                end
            end
            SCAN: begin
                if (abort) begin
                    msb_valid_d = 1'b0;
                    zero_d      = 1'b0;
                end else if (chunkHit) begin
                    msb_idx_d   = scanIdx;
                    msb_valid_d = 1'b1;
                    bit_idx_d   = scanIdx;
                end else if (chunk_q != '0) begin
                    chunk_d     = chunk_q - CPW'(1);
                end else begin
                    zero_d      = 1'b1;
                end
            end
            STREAM: begin
                if (abort) begin
                    msb_valid_d = 1'b0;
                    zero_d      = 1'b0;
                end else if (bit_ready && bit_idx_q != '0) begin
                    bit_idx_d   = bit_idx_q - IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q         <= '0;
            chunk_q     <= '0;
            msb_valid_q <= 1'b0;
            msb_idx_q   <= '0;
            zero_q      <= 1'b0;
            bit_idx_q   <= '0;
        end else begin
            k_q         <= k_d;
            chunk_q     <= chunk_d;
            msb_valid_q <= msb_valid_d;
            msb_idx_q   <= msb_idx_d;
            zero_q      <= zero_d;
            bit_idx_q   <= bit_idx_d;
        end
    end

    always_comb begin
        busy      = (state_q == SCAN) || (state_q == STREAM);
        bit_valid = (state_q == STREAM);
        done      = (state_q == DONE);
        bit_out   = bit_valid && k_q[bit_idx_q];
        last      = bit_valid && (bit_idx_q == '0);
    end

    assign msb_valid = msb_valid_q;
    assign msb_idx   = msb_idx_q;
    assign zero      = zero_q;
    assign bit_idx   = bit_idx_q;

endmodule

// File: tb/tb_scalar_bit_scanner.sv
// Bench for scalar_bit_scanner: a transaction-level model checked every cycle on the
// N=255/W=16 instance, plus literal expectations on both it and an N=8/W=1 instance.
module tb_scalar_bit_scanner;
    localparam int N = 255;
    localparam int W = 16;
    localparam int C = (N + W - 1) / W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, abort, bitReady;
    logic [N-1:0] k;
    logic         busy, msbValid, zero, bitValid, bitOut, last, done;
    logic [7:0]   msbIdx, bitIdx;

    logic         startB, abortB, readyB;
    logic [7:0]   kB;
    logic         busyB, msbValidB, zeroB, bitValidB, bitOutB, lastB, doneB;
    logic [2:0]   msbIdxB, bitIdxB;

    scalar_bit_scanner #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .k(k),
        .busy(busy), .msb_valid(msbValid), .msb_idx(msbIdx), .zero(zero),
        .bit_valid(bitValid), .bit_out(bitOut), .bit_idx(bitIdx),
        .bit_ready(bitReady), .last(last), .done(done)
    );

    scalar_bit_scanner #(.N(8), .W(1)) dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .abort(abortB), .k(kB),
        .busy(busyB), .msb_valid(msbValidB), .msb_idx(msbIdxB), .zero(zeroB),
        .bit_valid(bitValidB), .bit_out(bitOutB), .bit_idx(bitIdxB),
        .bit_ready(readyB), .last(lastB), .done(doneB)
    );

    int tests = 0;
    int failed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int highestSet(input logic [N-1:0] v);
        int h = -1;
        for (int i = 0; i < N; i++) if (v[8'(i)]) h = i;
        return h;
    endfunction

    // Model tracks only what the block promises: how long the scan takes, which bit is shown.
    typedef enum int {M_IDLE, M_SCAN, M_STREAM, M_DONE} mphase_e;
    mphase_e      mPhase;
    logic [N-1:0] mK;
    int           mMsb, mWait, mIdx;
    bit           mMsbValid, mZero;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase = M_IDLE; mK = '0; mMsb = -1; mWait = 0; mIdx = 0;
            mMsbValid = 1'b0; mZero = 1'b0;
        end else begin
            case (mPhase)
                M_IDLE: if (start) begin
                    mK = k; mMsb = highestSet(k); mMsbValid = 1'b0; mZero = 1'b0;
                    mWait = (mMsb < 0) ? C : C - mMsb / W;
                    mPhase = M_SCAN;
                end
                M_SCAN: if (abort) begin
                    mPhase = M_IDLE; mMsbValid = 1'b0; mZero = 1'b0;
                end else begin
                    mWait--;
                    if (mWait == 0) begin
                        if (mMsb < 0) begin mZero = 1'b1; mPhase = M_DONE; end
                        else begin mMsbValid = 1'b1; mIdx = mMsb; mPhase = M_STREAM; end
                    end
                end
                M_STREAM: if (abort) begin
                    mPhase = M_IDLE; mMsbValid = 1'b0; mZero = 1'b0;
                end else if (bitReady) begin
                    if (mIdx == 0) mPhase = M_DONE;
                    else mIdx--;
                end
                M_DONE: mPhase = M_IDLE;
                default: mPhase = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("busy", 64'(busy), 64'(mPhase == M_SCAN || mPhase == M_STREAM));
            checkOutput("bit_valid", 64'(bitValid), 64'(mPhase == M_STREAM));
            checkOutput("done", 64'(done), 64'(mPhase == M_DONE));
            checkOutput("msb_valid", 64'(msbValid), 64'(mMsbValid));
            checkOutput("zero", 64'(zero), 64'(mZero));
            if (mMsbValid) checkOutput("msb_idx", 64'(msbIdx), 64'(mMsb));
            if (mPhase == M_STREAM) begin
                checkOutput("bit_idx", 64'(bitIdx), 64'(mIdx));
                checkOutput("bit_out", 64'(bitOut), 64'(mK[8'(mIdx)]));
                checkOutput("last", 64'(last), 64'(mIdx == 0));
            end
        end
    end

    logic capBits[$];
    int   capIdx[$];
    logic capLast[$];

    always @(posedge clk) begin
        if (rst_n && bitValid && bitReady) begin
            capBits.push_back(bitOut);
            capIdx.push_back(int'(bitIdx));
            capLast.push_back(last);
        end
    end

    function automatic logic readyFor(input int mode, input int cyc);
        return (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    endfunction

    task automatic applyStimulus(input logic [N-1:0] kv, input int readyMode, input bit abortToo,
                                 input int maxCycles, output int msbLat, output int zeroLat,
                                 output int doneCnt);
        int cyc = 0;
        bit seenDone = 1'b0;
        capBits.delete(); capIdx.delete(); capLast.delete();
        msbLat = -1; zeroLat = -1; doneCnt = 0;
        @(negedge clk);
        k = kv; start = 1'b1; abort = abortToo; bitReady = readyFor(readyMode, 0);
        while (!seenDone && cyc < maxCycles) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (msbValid && msbLat < 0) msbLat = cyc;
            if (zero && zeroLat < 0) zeroLat = cyc;
            if (done) begin doneCnt++; seenDone = 1'b1; end
            cyc++;
            bitReady = readyFor(readyMode, cyc);
        end
        checkOutput("run_done_seen", 64'(seenDone), 64'(1));
        @(negedge clk);
        if (done) doneCnt++;
        bitReady = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
        checkOutput({tag, "_msb_valid"}, 64'(msbValid), 64'(0));
        checkOutput({tag, "_msb_idx"}, 64'(msbIdx), 64'(0));
        checkOutput({tag, "_zero"}, 64'(zero), 64'(0));
        checkOutput({tag, "_bit_valid"}, 64'(bitValid), 64'(0));
        checkOutput({tag, "_bit_out"}, 64'(bitOut), 64'(0));
        checkOutput({tag, "_bit_idx"}, 64'(bitIdx), 64'(0));
        checkOutput({tag, "_last"}, 64'(last), 64'(0));
        checkOutput({tag, "_done"}, 64'(done), 64'(0));
    endtask

    int exp4[9] = '{1, 1, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] kv;
        int msbLat, zeroLat, doneCnt, ones, lastCnt, dn;
        bit hit;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; bitReady = 1'b0; k = '0;
        startB = 1'b0; abortB = 1'b0; readyB = 1'b0; kB = '0;
        @(negedge clk); @(negedge clk);
        checkAllZero("reset");
        rst_n = 1'b1;

        $display("[TB] single top bit, ready always high");
        kv = '0; kv[254] = 1'b1;
        applyStimulus(kv, 0, 1'b0, 400, msbLat, zeroLat, doneCnt);
        checkOutput("t1_msb_latency", 64'(msbLat), 64'(1));
        checkOutput("t1_msb_idx", 64'(msbIdx), 64'(254));
        checkOutput("t1_handshakes", 64'(capBits.size()), 64'(255));
        ones = 0; lastCnt = 0;
        foreach (capBits[i]) ones += int'(capBits[i]);
        foreach (capLast[i]) lastCnt += int'(capLast[i]);
        checkOutput("t1_ones", 64'(ones), 64'(1));
        if (capBits.size() == 255) begin
            checkOutput("t1_first_bit", 64'(capBits[0]), 64'(1));
            checkOutput("t1_final_idx", 64'(capIdx[254]), 64'(0));
            checkOutput("t1_final_last", 64'(capLast[254]), 64'(1));
        end
        checkOutput("t1_last_count", 64'(lastCnt), 64'(1));
        checkOutput("t1_done_pulses", 64'(doneCnt), 64'(1));

        $display("[TB] all-zero scalar");
        applyStimulus('0, 0, 1'b0, 100, msbLat, zeroLat, doneCnt);
        checkOutput("t2_zero_latency", 64'(zeroLat), 64'(16));
        checkOutput("t2_no_msb_valid", 64'(msbLat), 64'(-1));
        checkOutput("t2_zero_held", 64'(zero), 64'(1));
        checkOutput("t2_no_bits", 64'(capBits.size()), 64'(0));
        checkOutput("t2_done_pulses", 64'(doneCnt), 64'(1));

        $display("[TB] k=5 with abort alongside start");
        applyStimulus(255'd5, 0, 1'b1, 100, msbLat, zeroLat, doneCnt);
        checkOutput("t3_msb_latency", 64'(msbLat), 64'(16));
        checkOutput("t3_msb_idx", 64'(msbIdx), 64'(2));
        checkOutput("t3_handshakes", 64'(capBits.size()), 64'(3));
        if (capBits.size() == 3) begin
            checkOutput("t3_bits", 64'({capBits[0], capBits[1], capBits[2]}), 64'(3'b101));
            checkOutput("t3_last", 64'({capLast[0], capLast[1], capLast[2]}), 64'(3'b001));
            checkOutput("t3_idx0", 64'(capIdx[0]), 64'(2));
            checkOutput("t3_idx2", 64'(capIdx[2]), 64'(0));
        end
        checkOutput("t3_done_pulses", 64'(doneCnt), 64'(1));

        $display("[TB] k=0x1F3 with ready stalls");
        applyStimulus(255'h1F3, 1, 1'b0, 200, msbLat, zeroLat, doneCnt);
        checkOutput("t4_msb_idx", 64'(msbIdx), 64'(8));
        checkOutput("t4_handshakes", 64'(capBits.size()), 64'(9));
        for (int i = 0; i < 9 && i < capBits.size(); i++) begin
            checkOutput($sformatf("t4_bit%0d", i), 64'(capBits[i]), 64'(exp4[i]));
            checkOutput($sformatf("t4_idx%0d", i), 64'(capIdx[i]), 64'(8 - i));
        end
        checkOutput("t4_done_pulses", 64'(doneCnt), 64'(1));

        $display("[TB] reset in the middle of a stream");
        kv = '0; kv[200] = 1'b1; kv[100] = 1'b1;
        @(negedge clk);
        k = kv; start = 1'b1; bitReady = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 300 && !hit; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bitValid && bitIdx == 8'd100) hit = 1'b1;
        end
        checkOutput("t5_reached_idx100", 64'(hit), 64'(1));
        #2 rst_n = 1'b0;
        #1 checkAllZero("t5_reset");
        @(negedge clk);
        checkOutput("t5_no_done", 64'(done), 64'(0));
        bitReady = 1'b0;
        rst_n = 1'b1;
        applyStimulus(255'd3, 0, 1'b0, 100, msbLat, zeroLat, doneCnt);
        checkOutput("t5_msb_idx", 64'(msbIdx), 64'(1));
        checkOutput("t5_handshakes", 64'(capBits.size()), 64'(2));

        $display("[TB] abort during scan");
        @(negedge clk);
        k = '0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("t7_busy_after_abort", 64'(busy), 64'(0));
        dn = 0;
        repeat (20) begin @(negedge clk); dn += int'(done); end
        checkOutput("t7_no_done", 64'(dn), 64'(0));

        $display("[TB] N=8 W=1 instance: start ignored and abort in stream");
        @(negedge clk); kB = 8'h40; startB = 1'b1;
        @(negedge clk); startB = 1'b0;
        checkOutput("t6_busy_scan", 64'(busyB), 64'(1));
        checkOutput("t6_msb_valid_c1", 64'(msbValidB), 64'(0));
        @(negedge clk);
        checkOutput("t6_msb_valid_c2", 64'(msbValidB), 64'(0));
        @(negedge clk);
        checkOutput("t6_msb_valid", 64'(msbValidB), 64'(1));
        checkOutput("t6_msb_idx", 64'(msbIdxB), 64'(6));
        checkOutput("t6_bit_valid", 64'(bitValidB), 64'(1));
        checkOutput("t6_bit_idx6", 64'(bitIdxB), 64'(6));
        checkOutput("t6_bit_out6", 64'(bitOutB), 64'(1));
        checkOutput("t6_last6", 64'(lastB), 64'(0));
        startB = 1'b1; kB = 8'hFF; readyB = 1'b1;
        @(negedge clk);
        startB = 1'b0;
        checkOutput("t6_bit_idx5", 64'(bitIdxB), 64'(5));
        checkOutput("t6_bit_out5", 64'(bitOutB), 64'(0));
        checkOutput("t6_msb_idx_held", 64'(msbIdxB), 64'(6));
        abortB = 1'b1; readyB = 1'b1;
        @(negedge clk);
        abortB = 1'b0; readyB = 1'b0;
        checkOutput("t6_busy_abort", 64'(busyB), 64'(0));
        checkOutput("t6_bit_valid_abort", 64'(bitValidB), 64'(0));
        checkOutput("t6_msb_valid_abort", 64'(msbValidB), 64'(0));
        checkOutput("t6_zero_abort", 64'(zeroB), 64'(0));
        dn = int'(doneB);
        repeat (3) begin @(negedge clk); dn += int'(doneB); end
        checkOutput("t6_no_done", 64'(dn), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/scalar_bit_scanner.md
Name: scalar_bit_scanner

Overview:
- Sequential, parametrised replacement for the flat 255-way combinational priority encoder used ahead of scalar multiplication.
- Latches an N-bit scalar and scans it W bits per cycle from the top to find the most-significant set bit.
- Streams the scalar bits MSB-first, from that index down to bit 0, over a valid/ready handshake into the point-multiplication ladder.
- Flags an all-zero scalar without streaming any bits.

Parameters:
- N, 255, scalar width in bits; N >= 2.
- W, 16, bits examined per scan cycle; 1 <= W <= N.
- IW, $clog2(N), index width (8 for N=255). Derived; do not override.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  latch k and begin a scan; sampled only in IDLE.
- abort  in  1  synchronous cancel; return to IDLE without a done pulse.
- k  in  N  scalar, sampled on an accepted start.
- busy  out  1  high in SCAN and STREAM.
- msb_valid  out  1  msb_idx is valid.
- msb_idx  out  IW  index of the highest set bit of k.
- zero  out  1  latched k was all zeros.
- bit_valid  out  1  bit_out/bit_idx are valid.
- bit_out  out  1  scalar bit at bit_idx.
- bit_idx  out  IW  index of the presented bit.
- bit_ready  in  1  consumer accepts the current bit.
- last  out  1  presented bit is bit 0.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - All outputs are 0, including msb_idx and bit_idx.
  - Internal scalar register and chunk pointer are cleared.
  - Reset mid-scan or mid-stream abandons the operation with no done pulse.
- Chunks:
  - C = ceil(N/W) chunks; chunk c covers bits [min(N-1, cW+W-1) : cW].
  - The top chunk is zero-padded.
- FSM states: IDLE, SCAN, STREAM, DONE.
- IDLE:
  - On start, latch k, set chunk pointer to C-1, clear msb_valid and zero, go to SCAN.
  - start in any other state is ignored.
- SCAN, one chunk per cycle:
  - If the current chunk is nonzero: msb_idx = cW + position of its highest set bit; msb_valid=1; bit_idx = msb_idx; go to STREAM.
  - Else if c == 0: zero=1, go to DONE.
  - Else: c decrements.
  - Latency from accepted start to msb_valid is (C-1-c_msb)+1 cycles; worst case is C cycles.
- STREAM:
  - bit_valid=1, bit_out = k[bit_idx], last = (bit_idx == 0).
  - On bit_valid && bit_ready: bit_idx decrements.
  - If last was also high on that handshake, bit_valid drops the next cycle and the FSM goes to DONE.
  - While bit_ready=0, bit_out, bit_idx and last hold stable.
  - Exactly msb_idx+1 handshakes per scalar.
- DONE: done=1 for exactly one cycle, then IDLE.
- Holding: msb_valid, msb_idx and zero hold until the next accepted start.
- abort: valid in SCAN or STREAM.
  - Next state IDLE; bit_valid=0, msb_valid=0, zero=0, no done pulse.
  - abort has priority over a simultaneous handshake.
- Simultaneous events: start and abort together in IDLE means start wins (abort is a no-op in IDLE).
- Arithmetic: bit_idx and the chunk pointer never wrap below 0; the FSM leaves STREAM on the last handshake.

Test Plan:
1. N=255, W=16, k=1<<254, bit_ready=1 -> msb_valid with msb_idx=254 one cycle after start; 255 handshakes; first bit_out=1, rest 0; last at bit_idx=0; done one cycle later.
2. k=0 -> 16 SCAN cycles, then zero=1, msb_valid=0, no bit_valid ever, done pulses once.
3. k=5 -> msb_idx=2 after 16 cycles; stream 1,0,1 with bit_idx 2,1,0; last high only on bit_idx=0.
4. k=0x1F3, bit_ready toggling 1,0,0,1,... -> bit_out/bit_idx stable while stalled; sequence 1,1,1,1,1,0,0,1,1 unchanged.
5. Reset asserted mid-stream at bit_idx=100 -> all outputs 0 immediately, no done; a new start with k=3 then yields msb_idx=1.
6. W=1, N=8, k=8'h40 -> msb_idx=6 after 2 scan cycles; start pulsed during STREAM is ignored; abort during STREAM returns to IDLE with no done pulse.
